// File: rtl/cube_link_receiver.sv
// Cube panel link receiver: oversamples the link, deserializes 12 lanes, captures one row frame per latch.
// Define CUBE_RX_GLITCH_FILTER_EN to require two matching samples before accepting serial_clk/latch edges.
module cube_link_receiver #(
   parameter int CHAIN_LEN = 64,
   parameter int CNT_W     = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   serial_clk,
   input  logic                   latch_enable,
   input  logic                   output_enable_n,
   input  logic [3:0]             serial_data_red,
   input  logic [3:0]             serial_data_green,
   input  logic [3:0]             serial_data_blue,
   input  logic [15:0]            row_select_n,
   output logic                   frame_valid,
   input  logic                   frame_ready,
   output logic [4*CHAIN_LEN-1:0] data_red,
   output logic [4*CHAIN_LEN-1:0] data_green,
   output logic [4*CHAIN_LEN-1:0] data_blue,
   output logic [3:0]             row_index,
   output logic [CNT_W-1:0]       on_time,
   output logic                   length_error,
   output logic                   row_error,
   output logic [7:0]             overrun_count
);
   localparam int BC_W = $clog2(CHAIN_LEN) + 2;
   localparam int PW   = 31;
   // Pin bundle: [30:15] row_n, 14 oe_n, 13 latch, 12 sclk, [11:8] blue, [7:4] green, [3:0] red
   localparam logic [PW-1:0] PIN_IDLE = {16'hFFFF, 1'b1, 1'b0, 1'b0, 12'h000};

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_CAPTURE = 2'd2} state_t;
   state_t state_q, state_d;

   logic [PW-1:0] pins, sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
   logic [1:0] prev_q, prev_d, rise;
   logic sclk_rise, latch_rise, capture;
   logic [3:0][CHAIN_LEN-1:0] sr_red_q, sr_red_d, sr_green_q, sr_green_d, sr_blue_q, sr_blue_d;
   logic [BC_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] on_cnt_q, on_cnt_d;
   logic [15:0] row_low;
   logic [3:0] row_idx;
   logic row_bad;
   logic valid_q, valid_d, len_err_q, len_err_d, row_err_q, row_err_d;
   logic [4*CHAIN_LEN-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
   logic [3:0] row_index_q, row_index_d;
   logic [CNT_W-1:0] on_time_q, on_time_d;
   logic [7:0] ovr_q, ovr_d;

   assign pins = {row_select_n, output_enable_n, latch_enable, serial_clk,
                  serial_data_blue, serial_data_green, serial_data_red};

   always_comb begin
      sync1_d = pins;
      sync2_d = sync1_q;
      sync3_d = sync2_q;
      prev_d  = sync3_q[13:12];
   end

`ifdef CUBE_RX_GLITCH_FILTER_EN
   // Filtered level only follows after two equal samples; an edge fires once on that transition.
   logic [1:0] filt_q, filt_d;
   always_comb begin
      filt_d = filt_q;
      for (int i = 0; i < 2; i++) begin
         if (sync3_q[12+i] == prev_q[i]) filt_d[i] = sync3_q[12+i];
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) filt_q <= 2'b00;
      else       filt_q <= filt_d;
   end
   assign rise = sync3_q[13:12] & prev_q & ~filt_q;
`else
   assign rise = sync3_q[13:12] & ~prev_q;
`endif

   assign sclk_rise  = rise[0];
   assign latch_rise = rise[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (latch_rise)     state_d = ST_CAPTURE;
            else if (sclk_rise) state_d = ST_SHIFT;
         end
         ST_SHIFT:   if (latch_rise) state_d = ST_CAPTURE;
         ST_CAPTURE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      capture = (state_q == ST_CAPTURE);
   end

   // A shift in the same cycle as the latch edge lands before CAPTURE reads the registers.
   always_comb begin
      sr_red_d   = sr_red_q;
      sr_green_d = sr_green_q;
      sr_blue_d  = sr_blue_q;
      bit_cnt_d  = bit_cnt_q;
      on_cnt_d   = on_cnt_q;
      if (sclk_rise) begin
         for (int k = 0; k < 4; k++) begin
            sr_red_d[k]   = {sr_red_q[k][CHAIN_LEN-2:0],   sync3_q[k]};
            sr_green_d[k] = {sr_green_q[k][CHAIN_LEN-2:0], sync3_q[4+k]};
            sr_blue_d[k]  = {sr_blue_q[k][CHAIN_LEN-2:0],  sync3_q[8+k]};
         end
         if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + BC_W'(1);
      end
      if (!sync3_q[14] && on_cnt_q != '1) on_cnt_d = on_cnt_q + CNT_W'(1);
      if (capture) begin
         bit_cnt_d = '0;
         on_cnt_d  = '0;
      end
   end

   always_comb begin
      row_low = ~sync3_q[30:15];
      row_idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (row_low[i]) row_idx = 4'(i);
      end
      row_bad = (row_low == 16'd0) || ((row_low & (row_low - 16'd1)) != 16'd0);
   end

   // Handshake: a frame is held until accepted; captures arriving while held and not accepted are dropped.
   always_comb begin
      valid_d     = valid_q;
      red_d       = red_q;
      green_d     = green_q;
      blue_d      = blue_q;
      row_index_d = row_index_q;
      on_time_d   = on_time_q;
      len_err_d   = len_err_q;
      row_err_d   = row_err_q;
      ovr_d       = ovr_q;
      if (valid_q && frame_ready) valid_d = 1'b0;
      if (capture) begin
         if (!valid_q || frame_ready) begin
            valid_d     = 1'b1;
            red_d       = sr_red_q;
            green_d     = sr_green_q;
            blue_d      = sr_blue_q;
            row_index_d = row_idx;
            on_time_d   = on_cnt_q;
            len_err_d   = (bit_cnt_q != BC_W'(CHAIN_LEN));
            row_err_d   = row_bad;
         end else if (ovr_q != 8'hFF) begin
            ovr_d = ovr_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q     <= PIN_IDLE;
         sync2_q     <= PIN_IDLE;
         sync3_q     <= PIN_IDLE;
         prev_q      <= 2'b00;
         sr_red_q    <= '0;
         sr_green_q  <= '0;
         sr_blue_q   <= '0;
         bit_cnt_q   <= '0;
         on_cnt_q    <= '0;
         valid_q     <= 1'b0;
         red_q       <= '0;
         green_q     <= '0;
         blue_q      <= '0;
         row_index_q <= 4'd0;
         on_time_q   <= '0;
         len_err_q   <= 1'b0;
         row_err_q   <= 1'b0;
         ovr_q       <= 8'd0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         sync3_q     <= sync3_d;
         prev_q      <= prev_d;
         sr_red_q    <= sr_red_d;
         sr_green_q  <= sr_green_d;
         sr_blue_q   <= sr_blue_d;
         bit_cnt_q   <= bit_cnt_d;
         on_cnt_q    <= on_cnt_d;
         valid_q     <= valid_d;
         red_q       <= red_d;
         green_q     <= green_d;
         blue_q      <= blue_d;
         row_index_q <= row_index_d;
         on_time_q   <= on_time_d;
         len_err_q   <= len_err_d;
         row_err_q   <= row_err_d;
         ovr_q       <= ovr_d;
      end
   end

   assign frame_valid   = valid_q;
   assign data_red      = red_q;
   assign data_green    = green_q;
   assign data_blue     = blue_q;
   assign row_index     = row_index_q;
   assign on_time       = on_time_q;
   assign length_error  = len_err_q;
   assign row_error     = row_err_q;
   assign overrun_count = ovr_q;
endmodule

// File: doc/cube_link_receiver.md
Name: cube_link_receiver

Overview:
- Far-end receiver for the cube panel link (serial clock, latch, output enable, 4 lanes each of red/green/blue serial data, 16 active-low row selects).
- Oversamples the link in the system clock domain, deserializes each lane, captures one row frame per latch pulse, checks framing, and presents the frame on a valid/ready handshake.
- Used for board-to-board loopback self-test and as a synthesizable bench monitor for the controller.

Parameters:
- CHAIN_LEN, 64, bits shifted per lane per latch period. Must be at least 2.
- CNT_W, 16, width of the on-time counter.

Ports:
- clk  input  1  system clock, 50 MHz
- reset  input  1  asynchronous, active-high reset
- serial_clk  input  1  link shift clock; period must be at least 4 clk periods
- latch_enable  input  1  link latch; rising edge ends a frame
- output_enable_n  input  1  link blanking, active low
- serial_data_red  input  4  red lanes; lane k is bit k
- serial_data_green  input  4  green lanes
- serial_data_blue  input  4  blue lanes
- row_select_n  input  16  active-low one-hot row select
- frame_valid  output  1  a captured frame is available
- frame_ready  input  1  consumer accepts the frame
- data_red  output  4*CHAIN_LEN  lane k occupies bits [k*CHAIN_LEN +: CHAIN_LEN]
- data_green  output  4*CHAIN_LEN  same packing as data_red
- data_blue  output  4*CHAIN_LEN  same packing as data_red
- row_index  output  4  decoded row
- on_time  output  CNT_W  clk cycles with output enable active during the frame
- length_error  output  1  bit count for this frame was not CHAIN_LEN
- row_error  output  1  row_select_n was not exactly one low at latch time
- overrun_count  output  8  frames dropped, saturating

Behaviour:
- Synchronization:
  - Every link input passes through a 2-FF synchronizer.
  - Edges are detected on the registered synchronizer output.
  - A pin edge is detected 3 clk cycles later.
- Shifting:
  - On each detected serial_clk rising edge, all 12 lane shift registers shift left and the sampled lane bit enters the LSB.
  - The first bit of a frame therefore ends in the MSB after CHAIN_LEN shifts.
  - The bit counter increments and saturates at its maximum value. It is clog2(CHAIN_LEN)+2 bits wide.
- State machine:
  - IDLE: no bits since the last latch. A serial_clk edge moves to SHIFT.
  - SHIFT: a latch edge moves to CAPTURE.
  - CAPTURE: lasts one cycle, then returns to IDLE. The bit counter and on-time counter clear.
  - A latch edge in IDLE also goes to CAPTURE. That frame is zero-length and sets length_error.
- Simultaneous events: if serial_clk and latch edges are detected in the same cycle, the shift happens first and the captured frame includes that bit.
- On-time counter: counts cycles where synchronized output_enable_n = 0 since the previous capture, saturating at 2^CNT_W-1.
- CAPTURE:
  - Loads data_*, row_index, on_time, length_error (bit count != CHAIN_LEN) and row_error.
  - row_index is the lowest low bit of row_select_n, or 0 if none is low.
  - frame_valid rises the cycle after CAPTURE, which is 5 clk cycles after the latch_enable pin edge.
- Handshake:
  - frame_valid stays high until a cycle with frame_ready = 1.
  - Outputs are stable while frame_valid is high.
  - If CAPTURE occurs while frame_valid=1 and frame_ready=0, the new frame is dropped, overrun_count increments (saturates at 255), and held outputs are unchanged.
  - If frame_ready=1 in the CAPTURE cycle, the old frame is consumed, the new frame loads, and frame_valid stays 1.
- Reset:
  - Clears all outputs to 0, plus the shift registers, counters, synchronizers (reset to idle levels: serial_clk 0, latch 0, oe_n 1, row_select_n all 1) and state (IDLE).
  - Reset mid-frame discards partial data.

Optional Feature:
- CUBE_RX_GLITCH_FILTER_EN defined:
  - An edge on serial_clk or latch_enable is accepted only if the new level is seen on 2 consecutive synchronized samples.
  - Detection latency becomes 4 clk and frame_valid latency becomes 6 clk.
  - Single-cycle pulses are ignored.
  - Minimum link clock period becomes 6 clk.
- Undefined: no filter; latencies are as in Behaviour.

Test Plan:
- Input: CHAIN_LEN=64, serial_clk period 8 clk, lane red0 sends 0xDEADBEEF_01234567 MSB first, other lanes 0, row_select_n=16'hFFF7, then latch. Required: frame_valid 5 clk after the latch pin edge; data_red[63:0]=64'hDEADBEEF01234567; row_index=3; length_error=0; row_error=0.
- Input: 63 shifts then latch. Required: length_error=1. Next frame of 64 shifts: length_error=0.
- Input: row_select_n=16'hFFFC at latch. Required: row_error=1, row_index=0. Input: row_select_n=16'hFFFF. Required: row_error=1.
- Input: frame_ready=0 across 3 latches. Required: first frame held, overrun_count=2. Input: frame_ready=1 on the 4th CAPTURE cycle. Required: 4th frame loads, frame_valid stays 1.
- Input: output_enable_n low for 100 clk during a frame. Required: on_time=100 (±2 for synchronizer alignment). Input: reset asserted mid-shift. Required: all outputs 0, state IDLE, next full frame captured correctly.
- Input: CUBE_RX_GLITCH_FILTER_EN defined, 1-clk glitch on serial_clk. Required: bit count unchanged, frame_valid latency 6 clk.
